// File: rtl/gpio_mul_core.sv
// gpio_mul_core: bus-mapped shift-add multiplier with popcount, status and completed-op counter.
// Result W/L/valid land one cycle before ready rises; done_irq pulses as ready returns.
module gpio_mul_core #(
    parameter int OP_W = 24,
    parameter int RES_W = 32,
    parameter int CNT_W = 16,
    parameter logic [15:0] BASE = 16'h0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_in_s_insp,
    output logic [31:0] gpio_out,
    output logic        done_irq
);
    localparam int AW = 2 * OP_W;
    localparam int IW = $clog2(OP_W);
    localparam int LW = $clog2(RES_W + 1);
    localparam logic [15:0] A_A1 = BASE;
    localparam logic [15:0] A_A2 = BASE + 16'h08;
    localparam logic [15:0] A_W = BASE + 16'h10;
    localparam logic [15:0] A_L = BASE + 16'h18;
    localparam logic [15:0] A_CTL = BASE + 16'h20;
    localparam logic [15:0] A_GIN = BASE + 16'h28;

    typedef enum logic [1:0] {IDLE, MULT, POPCNT, DONE} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  a1_q, a1_d, a2_q, a2_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [RES_W-1:0] w_q, w_d;
    logic [LW-1:0]    l_q, l_d, ones;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d, gin_q, gin_d, rdata;
    logic             ready_q, ready_d, valid_q, valid_d, irq_q, irq_d;

    always_comb begin
        ones = '0;
        for (int i = 0; i < RES_W; i++) ones = ones + LW'(acc_q[i]);
    end

    always_comb begin
        rdata = saddress == A_A1  ? 32'(a1_q) :
                saddress == A_A2  ? 32'(a2_q) :
                saddress == A_W   ? 32'(w_q) :
                saddress == A_L   ? 32'(l_q) :
                saddress == A_CTL ? {30'b0, ready_q, valid_q} :
                saddress == A_GIN ? gin_q : '0;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        w_d     = w_q;
        l_d     = l_q;
        valid_d = valid_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        rd_d    = srd ? rdata : rd_q;
        gin_d   = gpio_latch ? gpio_in : gin_q;
        // Operands are frozen while an operation is in flight.
        a1_d    = (swr && ready_q && saddress == A_A1) ? sdata_in[OP_W-1:0] : a1_q;
        a2_d    = (swr && ready_q && saddress == A_A2) ? sdata_in[OP_W-1:0] : a2_q;
        case (state_q)
            IDLE: if (swr && saddress == A_CTL) begin
                acc_d   = '0;
                idx_d   = '0;
                ready_d = 1'b0;
                state_d = MULT;
            end
            MULT: begin
                acc_d   = acc_q + (a2_q[idx_q] ? AW'(a1_q) << idx_q : '0);
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(OP_W - 1) ? POPCNT : MULT;
            end
            POPCNT: begin
                w_d     = acc_q[RES_W-1:0];
                l_d     = ones;
                valid_d = (acc_q >> RES_W) == '0;
                state_d = DONE;
            end
            default: begin
                ready_d = 1'b1;
                irq_d   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            w_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            gin_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            gin_q   <= gin_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            irq_q   <= irq_d;
        end
    end

    assign sdata_out      = rd_q;
    assign gpio_in_s_insp = gin_q;
    assign gpio_out       = 32'(cnt_q);
    assign done_irq       = irq_q;
endmodule

// File: doc/gpio_mul_core.md
Name: gpio_mul_core

Overview:
- Bus-mapped multiply/popcount peripheral for the GPIO emulation subsystem.
- Host writes two unsigned operands, then writes the control register to start.
- The block runs a sequential shift-add multiply (one operand bit per clock), then counts the ones in the result.
- Results and status are exposed on the same register window; a completed-operation counter drives gpio_out.

Parameters:
- OP_W, 24: operand width in bits; 2 ≤ OP_W ≤ 32.
- RES_W, 32: width of result register W; RES_W ≤ 2*OP_W and RES_W ≤ 32.
- CNT_W, 16: width of the completed-operation counter; CNT_W ≤ 32.
- BASE, 16'h0380: register window base address.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- saddress, input, 16: register address.
- srd, input, 1: read strobe, one cycle, sampled on clk.
- swr, input, 1: write strobe, one cycle, sampled on clk.
- sdata_in, input, 32: write data.
- sdata_out, output, 32: registered read data.
- gpio_in, input, 32: external input bus.
- gpio_latch, input, 1: capture enable for gpio_in, sampled on clk.
- gpio_in_s_insp, output, 32: the captured gpio_in value.
- gpio_out, output, 32: completed-operation counter, zero-extended.
- done_irq, output, 1: one-cycle pulse when a result becomes valid.

Behaviour:
- Register map (offsets from BASE):
  - +0x00 A1 (RW): holds OP_W bits; upper bits write-ignored, read 0.
  - +0x08 A2 (RW): same as A1.
  - +0x10 W (RO): result, RES_W bits.
  - +0x18 L (RO): popcount of W.
  - +0x20 CTRL/STATUS: write starts an operation (any data); read returns {30'b0, ready, valid}.
  - +0x28 GPIN (RO): gpio_in_s.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset: A1, A2, W, L, op counter, sdata_out, gpio_in_s and done_irq clear to 0. ready=1, valid=1 (status reads 2'b11). FSM goes to IDLE. Reset overrides any concurrent strobe or operation in progress; no partial result is retained.
- sdata_out is updated on the edge where srd=1. It holds its value otherwise, and is not cleared by non-read cycles.
- A read and a write in the same cycle: the write takes effect; the read returns the pre-write value.
- gpio_in_s <= gpio_in on every edge with gpio_latch=1.
- FSM states:
  - IDLE: on a write to CTRL, clear the accumulator (2*OP_W bits) and the bit index; ready<=0; go to MULT.
  - MULT: if A2[idx], accumulator += A1 << idx; idx++. Stay exactly OP_W cycles, then go to POPCNT.
  - POPCNT: W <= acc[RES_W-1:0]; L <= ones(acc[RES_W-1:0]); valid <= (acc[2*OP_W-1:RES_W] == 0), or 1 if RES_W == 2*OP_W. Go to DONE.
  - DONE: ready<=1; done_irq=1 for this cycle only; op counter += 1, wrapping modulo 2^CNT_W. Go to IDLE.
- Latency: with the start write sampled on edge E0, status reads ready=1 with W, L and valid updated after edge E0+OP_W+2. done_irq is high during the cycle following edge E0+OP_W+2.
- While busy (ready=0):
  - Writes to CTRL, A1 and A2 are ignored; the operands stay frozen.
  - W, L and valid keep their previous values until POPCNT.
- Start in the same cycle as writing A1/A2: the operand write takes effect; the start is honoured with the old operand values. Software must write the operands first.
- The multiply is unsigned only. The accumulator never truncates internally.

Test Plan:
- Reset, then read CTRL, W, L and gpio_out -> 0x3, 0, 0, 0; done_irq=0.
- A1=3, A2=5, start. Poll -> ready=0 for OP_W+2 cycles (26 at default), then W=15, L=4, status=0x3, gpio_out=1, one done_irq pulse.
- A1=0xFFFFFF, A2=0xFFFFFF, start -> W=0xFE000001, L=8, status=0x2 (overflow, valid=0).
- Start the 7×9 operation, then at cycle 5 write A1=100 and start again -> both ignored; result W=63, gpio_out increments by exactly 1.
- Assert reset during MULT of any operation -> status 0x3, W=0, gpio_out=0, no done_irq; a subsequent 2×2 operation gives W=4, L=1.
- gpio_in=0xA5A5A5A5 with gpio_latch pulsed, then gpio_in changed -> GPIN and gpio_in_s_insp read 0xA5A5A5A5; a simultaneous srd+swr to A1 returns the old A1 value.
